tx_frame_ctrl: RTL and testbench

Frame-level scheduler for the DCSK transmitter. It buffers message words from the host in a small FIFO and, per frame, loads the chaos seed into the TX datapath once. It then issues one send per word, waits for the chip counter to finish each word, and reports frame completion, underrun, abort and timeout status. It sits between the host/bus side and the `tx` top, driving its seed/load/send/msg/sf inputs.

---
 rtl/tx_frame_ctrl.sv | 175 +++++++++++++++++
 tb/tb_tx_frame_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_ctrl.sv
// Frame scheduler for the DCSK transmitter: buffers host words, loads the chaos
// seed once per frame, issues one send per word and reports frame status.
module tx_frame_ctrl #(
  parameter int unsigned MSG_W        = 32,
  parameter int unsigned SEED_W       = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                              i_clk,
  input  logic                              i_arst_n,
  input  logic                              i_msg_valid,
  input  logic [MSG_W-1:0]                  i_msg_data,
  output logic                              o_msg_ready,
  input  logic                              i_start,
  input  logic                              i_abort,
  input  logic [SEED_W-1:0]                 i_cfg_seed,
  input  logic [4:0]                        i_cfg_sf,
  input  logic [3:0]                        i_frame_len,
  input  logic                              i_tx_busy,
  output logic [SEED_W-1:0]                 o_seed,
  output logic                              o_load_seed,
  output logic                              o_send,
  output logic [MSG_W-1:0]                  o_msg,
  output logic [4:0]                        o_sf,
  output logic                              o_busy,
  output logic                              o_frame_done,
  output logic                              o_aborted,
  output logic                              o_underrun,
  output logic                              o_error,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 2);
  localparam int unsigned TMO_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [MSG_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_d;
  logic               push;
  logic               busy_q;
  logic [3:0]         remaining_q, remaining_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               error_d;
  logic               send_d;
  logic [MSG_W-1:0]   msg_d;
  logic               start_acc;

  assign o_msg_ready = (o_fifo_count < CNT_W'(FIFO_DEPTH));
  assign o_underrun  = (state_q == S_ISSUE) && (o_fifo_count == '0);
  assign push        = i_msg_valid && o_msg_ready;
  assign start_acc   = (state_q == S_IDLE) && i_start;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_cnt_d   = '0;
    tmo_cnt_d   = '0;
    error_d     = o_error;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_SEED;
          remaining_d = (i_frame_len == 4'd0) ? 4'd1 : i_frame_len;
          error_d     = 1'b0;
        end
      end
      S_SEED: state_d = S_ISSUE;
      S_ISSUE: begin
        if (o_fifo_count != '0) state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (busy_q) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_cnt_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!busy_q) begin
          remaining_d = remaining_q - 4'd1;
          if (remaining_q == 4'd1)  state_d = S_DONE;
          else if (GAP_CYCLES == 0) state_d = S_ISSUE;
          else                      state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = S_ISSUE;
        else                                     gap_cnt_d = gap_cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      error_d = o_error;
    end
  end

  // Outputs are registered from next-state, so o_send lands in the ISSUE cycle
  // itself; ISSUE with a non-empty FIFO is then exactly the cycle o_send is high,
  // which makes o_send the pop strobe. ISSUE is never entered from a popping
  // cycle, so the next head is the current head, or the word landing in an empty FIFO.
  always_comb begin
    count_d = o_fifo_count + CNT_W'(push) - CNT_W'(o_send);
    send_d  = (state_d == S_ISSUE) && (count_d != '0);
    msg_d   = o_msg;
    if (send_d) msg_d = (o_fifo_count != '0) ? mem[rd_ptr] : i_msg_data;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_msg_data;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      gap_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      busy_q       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_count <= '0;
      o_seed       <= '0;
      o_sf         <= '0;
      o_load_seed  <= 1'b0;
      o_send       <= 1'b0;
      o_msg        <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_aborted    <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      gap_cnt_q    <= gap_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      // TX busy passes through one register; a fall at t is acted on at t+1.
      busy_q       <= i_tx_busy;
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (o_send) rd_ptr <= rd_ptr + 1'b1;
      o_fifo_count <= count_d;
      if (start_acc) begin
        o_seed <= i_cfg_seed;
        o_sf   <= i_cfg_sf;
      end
      o_load_seed  <= (state_d == S_SEED);
      o_send       <= send_d;
      o_msg        <= msg_d;
      o_busy       <= (state_d != S_IDLE);
      o_frame_done <= (state_d == S_DONE);
      o_aborted    <= i_abort && (state_q != S_IDLE);
      o_error      <= error_d;
    end
  end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Directed bench for tx_frame_ctrl: FIFO fill table, normal frame timeline,
// underrun, abort, busy timeout and asynchronous reset mid-frame.
module tb_tx_frame_ctrl;

  logic        clk = 1'b0;
  logic        i_arst_n = 1'b0;
  logic        i_msg_valid = 1'b0;
  logic [31:0] i_msg_data = '0;
  logic        o_msg_ready;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [31:0] i_cfg_seed = '0;
  logic [4:0]  i_cfg_sf = '0;
  logic [3:0]  i_frame_len = '0;
  logic        i_tx_busy = 1'b0;
  logic [31:0] o_seed;
  logic        o_load_seed;
  logic        o_send;
  logic [31:0] o_msg;
  logic [4:0]  o_sf;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_aborted;
  logic        o_underrun;
  logic        o_error;
  logic [2:0]  o_fifo_count;

  always #5 clk = ~clk;

  tx_frame_ctrl #(
    .MSG_W(32), .SEED_W(32), .FIFO_DEPTH(4), .GAP_CYCLES(2), .BUSY_TIMEOUT(15)
  ) dut (
    .i_clk(clk), .i_arst_n(i_arst_n),
    .i_msg_valid(i_msg_valid), .i_msg_data(i_msg_data), .o_msg_ready(o_msg_ready),
    .i_start(i_start), .i_abort(i_abort), .i_cfg_seed(i_cfg_seed), .i_cfg_sf(i_cfg_sf),
    .i_frame_len(i_frame_len), .i_tx_busy(i_tx_busy),
    .o_seed(o_seed), .o_load_seed(o_load_seed), .o_send(o_send), .o_msg(o_msg),
    .o_sf(o_sf), .o_busy(o_busy), .o_frame_done(o_frame_done), .o_aborted(o_aborted),
    .o_underrun(o_underrun), .o_error(o_error), .o_fifo_count(o_fifo_count)
  );

  typedef struct {
    logic        valid;
    logic [31:0] data;
    int          exp_count;
    logic        exp_ready;
  } fifo_vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] msg;
  } send_exp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit tx_en = 1'b0;
  int tx_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One clock; TX model raises busy the cycle after a send and holds it 20 cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (tx_left > 0) begin
      i_tx_busy = 1'b1;
      tx_left--;
    end else begin
      i_tx_busy = 1'b0;
    end
    if (tx_en && o_send) tx_left = 20;
  endtask

  task automatic push_word(input logic [31:0] d);
    i_msg_valid = 1'b1;
    i_msg_data  = d;
    tick();
    i_msg_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [3:0] len, input logic [4:0] sf, input logic [31:0] seed);
    i_start     = 1'b1;
    i_frame_len = len;
    i_cfg_sf    = sf;
    i_cfg_seed  = seed;
    cyc = 0;
    tick();
    i_start = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"},      o_busy, 0);
    chk({tag, "_load"},      o_load_seed, 0);
    chk({tag, "_send"},      o_send, 0);
    chk({tag, "_done"},      o_frame_done, 0);
    chk({tag, "_aborted"},   o_aborted, 0);
    chk({tag, "_underrun"},  o_underrun, 0);
    chk({tag, "_error"},     o_error, 0);
    chk({tag, "_seed"},      o_seed, 0);
    chk({tag, "_sf"},        o_sf, 0);
    chk({tag, "_msg"},       o_msg, 0);
    chk({tag, "_count"},     o_fifo_count, 0);
    chk({tag, "_ready"},     o_msg_ready, 1);
  endtask

  task automatic do_reset();
    i_arst_n = 1'b0;
    i_msg_valid = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    tx_left = 0; i_tx_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_arst_n = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    fifo_vec_t fv[6];
    send_exp_t se[3];
    int send_c[$];
    logic [31:0] send_m[$];
    int load_c, done_n, done_c, idle_c, n_send, n_done, push_c;
    logic [31:0] load_seed_v;

    fv[0] = '{1'b1, 32'hD000_0000, 1, 1'b1};
    fv[1] = '{1'b1, 32'hD000_0001, 2, 1'b1};
    fv[2] = '{1'b1, 32'hD000_0002, 3, 1'b1};
    fv[3] = '{1'b1, 32'hD000_0003, 4, 1'b0};
    fv[4] = '{1'b1, 32'hD000_0004, 4, 1'b0};
    fv[5] = '{1'b0, 32'h0000_0000, 4, 1'b0};
    se[0] = '{2,  32'hA5A5_0001};
    se[1] = '{27, 32'hA5A5_0002};
    se[2] = '{52, 32'hA5A5_0003};

    // Reset values
    #3;
    chk_reset_state("rst");
    do_reset();

    // FIFO fill: fifth push ignored
    for (int i = 0; i < 6; i++) begin
      i_msg_valid = fv[i].valid;
      i_msg_data  = fv[i].data;
      tick();
      i_msg_valid = 1'b0;
      chk($sformatf("fifo_count_%0d", i), o_fifo_count, fv[i].exp_count);
      chk($sformatf("fifo_ready_%0d", i), o_msg_ready, fv[i].exp_ready);
    end

    // Normal frame
    do_reset();
    tx_en = 1'b1;
    push_word(32'hA5A5_0001);
    push_word(32'hA5A5_0002);
    push_word(32'hA5A5_0003);
    start_frame(4'd3, 5'd16, 32'h1234_5678);
    chk("frame_busy_c1", o_busy, 1);
    load_c = -1; done_n = 0; done_c = -1; idle_c = -1; load_seed_v = '0;
    while (cyc <= 90) begin
      if (o_load_seed) begin load_c = cyc; load_seed_v = o_seed; end
      if (o_send) begin send_c.push_back(cyc); send_m.push_back(o_msg); end
      if (o_frame_done) begin done_n++; done_c = cyc; end
      if (!o_busy && idle_c < 0) idle_c = cyc;
      tick();
    end
    chk("frame_load_cyc", load_c, 1);
    chk("frame_load_seed", load_seed_v, 32'h1234_5678);
    chk("frame_sf", o_sf, 16);
    chk("frame_n_sends", send_c.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < send_c.size()) begin
        chk($sformatf("frame_send_cyc_%0d", i), send_c[i], se[i].cyc);
        chk($sformatf("frame_send_msg_%0d", i), send_m[i], se[i].msg);
      end
    end
    chk("frame_done_n", done_n, 1);
    chk("frame_done_cyc", done_c, 75);
    chk("frame_idle_cyc", idle_c, 76);
    chk("frame_count_end", o_fifo_count, 0);

    // Underrun: len=2 with one word buffered
    do_reset();
    push_word(32'hB000_0001);
    start_frame(4'd2, 5'd8, 32'h0BAD_F00D);
    while (!o_underrun && cyc < 60) tick();
    chk("underrun_seen", o_underrun, 1);
    chk("underrun_cyc", cyc, 27);
    repeat (3) tick();
    chk("underrun_hold", o_underrun, 1);
    chk("underrun_no_send", o_send, 0);
    push_word(32'hB000_0002);
    chk("underrun_send", o_send, 1);
    chk("underrun_msg", o_msg, 32'hB000_0002);
    chk("underrun_clear", o_underrun, 0);
    n_done = 0;
    for (int i = 0; i < 60 && n_done == 0; i++) begin
      tick();
      if (o_frame_done) n_done++;
    end
    chk("underrun_frame_done", n_done, 1);

    // Abort during WAIT_DONE of word 1 of 3
    do_reset();
    push_word(32'hC000_0001);
    push_word(32'hC000_0002);
    push_word(32'hC000_0003);
    start_frame(4'd3, 5'd4, 32'h5555_AAAA);
    while (cyc < 10) tick();
    chk("abort_busy_before", o_busy, 1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_pulse", o_aborted, 1);
    chk("abort_idle", o_busy, 0);
    chk("abort_no_send", o_send, 0);
    chk("abort_count", o_fifo_count, 2);
    tick();
    chk("abort_pulse_end", o_aborted, 0);
    n_send = 0; n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_send) n_send++;
      if (o_frame_done) n_done++;
    end
    chk("abort_no_more_sends", n_send, 0);
    chk("abort_no_done", n_done, 0);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_idle_ignored", o_aborted, 0);
    start_frame(4'd2, 5'd4, 32'h5555_AAAA);
    tick();
    chk("abort_kept_send", o_send, 1);
    chk("abort_kept_msg", o_msg, 32'hC000_0002);

    // Busy timeout, then cleared by the next start
    do_reset();
    tx_en = 1'b0;
    push_word(32'hE000_0001);
    start_frame(4'd1, 5'd2, 32'h0000_0001);
    n_done = 0;
    while (!o_error && cyc < 40) begin
      tick();
      if (o_frame_done) n_done++;
    end
    chk("tmo_error", o_error, 1);
    chk("tmo_cyc", cyc, 18);
    chk("tmo_idle", o_busy, 0);
    chk("tmo_no_done", n_done, 0);
    tx_en = 1'b1;
    push_word(32'hE000_0002);
    chk("tmo_sticky", o_error, 1);
    start_frame(4'd1, 5'd2, 32'h0000_0002);
    chk("tmo_cleared", o_error, 0);
    n_done = 0;
    for (int i = 0; i < 60 && n_done == 0; i++) begin
      tick();
      if (o_frame_done) n_done++;
    end
    chk("tmo_next_frame_done", n_done, 1);

    // Asynchronous reset mid-frame
    do_reset();
    push_word(32'hF000_0001);
    push_word(32'hF000_0002);
    start_frame(4'd2, 5'd9, 32'hCAFE_0001);
    while (cyc < 8) tick();
    push_c = o_fifo_count;
    chk("midrst_pre_busy", o_busy, 1);
    chk("midrst_pre_count", push_c, 1);
    #2;
    i_arst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    tx_left = 0;
    i_tx_busy = 1'b0;
    @(negedge clk);
    i_arst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
